// File: rtl/bit_deserializer.sv
// Serial-to-parallel word assembler, LSB-first, with valid/ready on both sides.
// Define PARITY_CHK_EN to expect an even-parity bit after each word and flag errors on out_err.
module bit_deserializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_CHK_EN
  typedef enum logic [1:0] {COLLECT, PARITY, HOLD} state_t;
`else
  typedef enum logic [1:0] {COLLECT, HOLD} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] data;

  // Input side stalls whenever a finished word is waiting downstream.
  assign in_ready = ~out_valid;
  assign out_data = data;

`ifdef PARITY_CHK_EN
  logic par;
  logic err;
  assign out_err = err;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      data      <= '0;
      out_valid <= 1'b0;
`ifdef PARITY_CHK_EN
      par       <= 1'b0;
      err       <= 1'b0;
`endif
    end else if (flush) begin
      state     <= COLLECT;
      cnt       <= '0;
      data      <= '0;
      out_valid <= 1'b0;
`ifdef PARITY_CHK_EN
      par       <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: if (in_valid) begin
          data[cnt] <= in_bit;
`ifdef PARITY_CHK_EN
          par <= par ^ in_bit;
`endif
          if (cnt == LAST) begin
            cnt <= '0;
`ifdef PARITY_CHK_EN
            state <= PARITY;
`else
            state     <= HOLD;
            out_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PARITY_CHK_EN
        PARITY: if (in_valid) begin
          err       <= par ^ in_bit;
          par       <= 1'b0;
          state     <= HOLD;
          out_valid <= 1'b1;
        end
`endif
        HOLD: if (out_ready) begin
          state     <= COLLECT;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= COLLECT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench for bit_deserializer (WIDTH=32); words queued when sent, checked on handshake.
module tb_bit_deserializer;
  localparam int W = 32;
`ifdef PARITY_CHK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_err;
  logic [W-1:0] out_data;

  typedef struct packed { logic [W-1:0] d; logic e; } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;

  bit_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  // Pop and compare every word the DUT hands over.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      exp_t e;
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected out_data=%h", out_data);
      end else begin
        e = q.pop_front();
        if (out_data !== e.d || out_err !== e.e || rev(out_data) !== rev(e.d)) begin
          mismatched++;
          $display("FAIL sb_word got=%h err=%b rev=%h exp=%h err=%b rev=%h",
                   out_data, out_err, rev(out_data), e.d, e.e, rev(e.d));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    int t = 0;
    in_valid = 1'b1; in_bit = b;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      compared++; mismatched++;
      $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic p, input bit push, input int gap_pct);
    exp_t e;
    e.d = w; e.e = PAR ? (^w ^ p) : 1'b0;
    if (push) q.push_back(e);
    for (int i = 0; i < W; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
      send_bit(w[i]);
    end
    if (PAR) send_bit(p);
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_err", W'(out_err), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 32'hA5A50F0F;
    send_word(w, ^w, 1, 0);
    chk("basic_valid_rise", W'(out_valid), W'(1));
    chk("basic_data", out_data, w);
    chk("basic_rev", rev(out_data), 32'hF0F0A5A5);
    @(posedge clk); #1;
    chk("basic_valid_one_cycle", W'(out_valid), '0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_word(32'h1, 1'b1, 1, 0);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_data", out_data, 32'h1);
      chk("bp_in_ready", W'(in_ready), '0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", W'(out_valid), '0);
    drain();
    send_word(32'h8000_0000, 1'b1, 1, 0);
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", W'(out_valid), '0);
    send_word(32'h0, 1'b0, 1, 0);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    rst_n = 1'b0; #1;
    chk("rmid_valid", W'(out_valid), '0);
    chk("rmid_data", out_data, '0);
    @(negedge clk);
    chk("rmid_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(32'hFFFFFFFF, 1'b0, 1, 0);
    drain();
    out_ready = 1'b0;
    send_word(32'h1234_5678, 1'b1, 0, 0);
    chk("rhold_valid_pre", W'(out_valid), W'(1));
    rst_n = 1'b0; #1;
    chk("rhold_valid", W'(out_valid), '0);
    chk("rhold_data", out_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send_word(32'h0000_00F0, 1'b0, 1, 0);
    drain();
  endtask

  task automatic test_parity_or_overrun();
`ifdef PARITY_CHK_EN
    send_word(32'h3, 1'b0, 1, 0);
    drain();
    send_word(32'h7, 1'b0, 1, 0);
    drain();
`else
    exp_t e;
    e.e = 1'b0;
    e.d = 32'hFFFFFFFF; q.push_back(e);
    e.d = 32'h00000001; q.push_back(e);
    for (int i = 0; i < 33; i++) send_bit(1'b1);
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    drain();
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] w;
      logic p;
      w = $urandom;
      p = ($urandom_range(9) == 0) ? ~(^w) : ^w;
      send_word(w, p, 1, 30);
    end
    idle(2);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_parity_or_overrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
